// File: rtl/up_sampler.sv
// ---------------------------------------------------------------------------
// up_sampler : 2x nearest-neighbour upsampler (pixel doubled, row replayed)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module up_sampler #(
  parameter int IN_WIDTH  = 400,
  parameter int IN_HEIGHT = 300,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_sol,
  output logic              out_eol,
  output logic              frame_done
);

  localparam int AW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [CW-1:0] C_FETCH_END = CW'(IN_WIDTH);
  localparam logic [AW-1:0] C_COL_LAST  = AW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_LAST  = RW'(IN_HEIGHT - 1);

  typedef enum logic [0:0] {
    LIVE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t            state_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_fetch_q;
  logic [AW-1:0]     col_out_q;
  logic              phase_q;
  logic [DATA_W-1:0] pix_q;
  logic              pix_full_q;
  logic              rd_pending_q;
  logic              frame_done_q;
  logic [DATA_W-1:0] lb_rdata_q;
  logic [DATA_W-1:0] line_buf [IN_WIDTH];

  logic          fetch_ok;
  logic          lb_rd_en;
  logic          beat_acc;
  logic          load;
  logic [AW-1:0] fetch_idx;

  assign fetch_ok   = !rst && !pix_full_q && !rd_pending_q && (col_fetch_q < C_FETCH_END);
  assign fifo_rd_en = fetch_ok && (state_q == LIVE) && !fifo_empty;
  assign lb_rd_en   = fetch_ok && (state_q == REPLAY);
  assign fetch_idx  = col_fetch_q[AW-1:0];
  // Line-buffer data is always ready the cycle after its read; FIFO data only when qualified.
  assign load       = rd_pending_q && ((state_q == REPLAY) || fifo_valid);
  assign beat_acc   = pix_full_q && out_ready;

  assign out_valid  = pix_full_q;
  assign out_pixel  = pix_q;
  assign out_sol    = pix_full_q && (col_out_q == '0) && !phase_q;
  assign out_eol    = pix_full_q && (col_out_q == C_COL_LAST) && phase_q;
  assign out_sof    = out_sol && (row_q == '0) && (state_q == LIVE);
  assign frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (!rst && (state_q == LIVE) && rd_pending_q && fifo_valid) begin
      line_buf[fetch_idx] <= fifo_dout;
    end
    if (lb_rd_en) begin
      lb_rdata_q <= line_buf[fetch_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LIVE;
      row_q        <= '0;
      col_fetch_q  <= '0;
      col_out_q    <= '0;
      phase_q      <= 1'b0;
      pix_q        <= '0;
      pix_full_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (fifo_rd_en || lb_rd_en) begin
        rd_pending_q <= 1'b1;
      end
      // A load only happens with pix_full clear, so it never collides with an accept.
      if (load) begin
        pix_q        <= (state_q == LIVE) ? fifo_dout : lb_rdata_q;
        pix_full_q   <= 1'b1;
        rd_pending_q <= 1'b0;
        col_fetch_q  <= col_fetch_q + CW'(1);
      end
      if (beat_acc) begin
        if (!phase_q) begin
          phase_q <= 1'b1;
        end else begin
          phase_q    <= 1'b0;
          pix_full_q <= 1'b0;
          col_out_q  <= col_out_q + AW'(1);
          if (col_out_q == C_COL_LAST) begin
            col_out_q   <= '0;
            col_fetch_q <= '0;
            if (state_q == LIVE) begin
              state_q <= REPLAY;
            end else begin
              state_q <= LIVE;
              if (row_q == C_ROW_LAST) begin
                row_q        <= '0;
                frame_done_q <= 1'b1;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_up_sampler.sv
// ---------------------------------------------------------------------------
// tb_up_sampler : scoreboard bench for up_sampler (IN_WIDTH=4, IN_HEIGHT=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_up_sampler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dout;
  logic          fifo_valid;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] out_pixel;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_sol;
  logic          out_eol;
  logic          frame_done;

  always #5 clk = ~clk;

  up_sampler #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  // FIFO source: automatic queue-backed model or manual override.
  logic          auto_fifo;
  logic [DW-1:0] a_dout, m_dout;
  logic          a_valid, m_valid;
  logic          a_empty, m_empty;
  logic [DW-1:0] fq [$];

  assign fifo_dout  = auto_fifo ? a_dout  : m_dout;
  assign fifo_valid = auto_fifo ? a_valid : m_valid;
  assign fifo_empty = auto_fifo ? a_empty : m_empty;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          sof;
    logic          sol;
    logic          eol;
    logic          last;
  } beat_t;

  beat_t exp_q [$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    beats_seen = 0;
  int    fd_count   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of one frame: each pixel twice, each row live then replayed.
  task automatic push_frame(input logic [DW-1:0] px [W*H]);
    for (int r = 0; r < H; r++) begin
      for (int cp = 0; cp < 2; cp++) begin
        for (int c = 0; c < W; c++) begin
          exp_q.push_back('{pix: px[r*W+c], sof: (r == 0 && cp == 0 && c == 0),
                            sol: (c == 0), eol: 1'b0, last: 1'b0});
          exp_q.push_back('{pix: px[r*W+c], sof: 1'b0, sol: 1'b0, eol: (c == W-1),
                            last: (r == H-1 && cp == 1 && c == W-1)});
        end
      end
    end
  endtask

  task automatic wait_beats(input int n, input string name);
    int cyc = 0;
    while (beats_seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (beats_seen < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: beats %0d, expected %0d", name, beats_seen, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // FIFO model: data returned the cycle after a sampled read strobe.
  initial begin
    logic rd;
    a_valid = 1'b0;
    a_dout  = '0;
    a_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd = auto_fifo && fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd && fq.size() > 0) begin
        a_dout  = fq.pop_front();
        a_valid = 1'b1;
      end else begin
        a_valid = 1'b0;
      end
      a_empty = (fq.size() == 0);
    end
  end

  // Monitor: compares every accepted beat and every frame_done against expectations.
  initial begin
    beat_t e;
    logic  fd_exp;
    fd_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        fd_exp = 1'b0;
      end else begin
        if (frame_done === 1'b1) fd_count++;
        if (frame_done !== 1'b0 || fd_exp) check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        fd_exp = 1'b0;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got pixel %0d, expected no beat", out_pixel);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("beat%0d_pix", beats_seen), {24'd0, out_pixel}, {24'd0, e.pix});
            check($sformatf("beat%0d_flags", beats_seen), {29'd0, out_sof, out_sol, out_eol},
                  {29'd0, e.sof, e.sol, e.eol});
            if (e.last) fd_exp = 1'b1;
          end
          beats_seen++;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] frame_px [W*H];
    int            got;
    frame_px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    rst       = 1'b1;
    out_ready = 1'b1;
    auto_fifo = 1'b0;
    m_empty   = 1'b0;
    m_valid   = 1'b0;
    m_dout    = '0;

    // Reset with a non-empty FIFO: everything quiet.
    repeat (3) begin
      @(negedge clk);
      check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_frame_done", {31'd0, frame_done}, 0);
      check("rst_markers", {29'd0, out_sof, out_sol, out_eol}, 0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    auto_fifo = 1'b1;

    // Frame 1, with a 5-cycle backpressure on the phase-0 beat of pixel 20.
    push_frame(frame_px);
    for (int i = 0; i < W*H; i++) fq.push_back(frame_px[i]);
    wait_beats(2, "f1_first_pair");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
    end
    check("stall_valid_seen", got, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_pixel", {24'd0, out_pixel}, 20);
      check("stall_no_rd", {31'd0, fifo_rd_en}, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("frame1");
    check("frame1_beats", beats_seen, 32);
    check("frame1_done_pulses", fd_count, 1);

    // Frame 2: FIFO runs dry after pixel 20.
    push_frame(frame_px);
    fq.push_back(8'd10);
    fq.push_back(8'd20);
    wait_beats(36, "f2_first_four");
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("empty_out_valid", {31'd0, out_valid}, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 2; i < W*H; i++) fq.push_back(frame_px[i]);
    wait_drain("frame2");
    check("frame2_beats", beats_seen, 64);
    check("frame2_done_pulses", fd_count, 2);

    // Reset right after a read strobe; a stale fifo_valid follows release.
    @(posedge clk);
    #1;
    auto_fifo = 1'b0;
    m_empty   = 1'b0;
    m_valid   = 1'b0;
    @(negedge clk);
    check("pre_rst_rd_en", {31'd0, fifo_rd_en}, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_valid = 1'b1;
    m_dout  = 8'd99;
    @(negedge clk);
    check("post_rst_fresh_rd", {31'd0, fifo_rd_en}, 1);
    exp_q.push_back('{pix: 8'd55, sof: 1'b1, sol: 1'b1, eol: 1'b0, last: 1'b0});
    exp_q.push_back('{pix: 8'd55, sof: 1'b0, sol: 1'b0, eol: 1'b0, last: 1'b0});
    @(posedge clk);
    #1;
    m_valid = 1'b1;
    m_dout  = 8'd55;
    m_empty = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    wait_beats(66, "post_rst_beats");
    repeat (4) @(negedge clk);
    check("post_rst_queue", exp_q.size(), 0);
    check("post_rst_idle", {31'd0, out_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
